// File: rtl/cla_checker.sv
// cla_checker
//   Result monitor for a registered carry-lookahead adder. It samples each
//   operand pair, delays it by the adder's pipeline latency, and compares the
//   adder's {C16, S} against the zero-extended A+B. It reports a compare
//   count, a mismatch count, the operands of the first mismatch, and pass/fail.
//
// Parameters
//   WIDTH   operand / sum width
//   LATENCY adder latency in cycles (1..8)
//   CNT_W   width of the compare and error counters (saturating)
//
// Ports
//   Clk            rising-edge clock
//   Rst            synchronous active-low reset
//   Start          pulse: begin a run (from IDLE or DONE)
//   Stop           pulse: end a run once in-flight compares drain
//   In_Valid       A/B form a pair to check this cycle
//   A, B           operands, as driven to the adder
//   S, C16         adder sum and carry-out
//   Busy           high in RUN or DRAIN
//   Done           high in DONE
//   Pass           high in DONE when no mismatch was seen
//   Chk_Cnt        compares performed
//   Err_Cnt        mismatches seen
//   First_Err_A/B  operands of the first mismatch
//
// Build option
//   CLA_CHK_HALT_EN  when defined, the first mismatch ends the run at once.
module cla_checker #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Stop,
  input  logic             In_Valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] S,
  input  logic             C16,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [CNT_W-1:0] Chk_Cnt,
  output logic [CNT_W-1:0] Err_Cnt,
  output logic [WIDTH-1:0] First_Err_A,
  output logic [WIDTH-1:0] First_Err_B
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0]       DRAIN_LAST = 4'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [WIDTH-1:0] OPD_ZERO   = {WIDTH{1'b0}};

  // Reference sum: zero-extended so the carry lands in the top bit.
  function automatic logic [WIDTH:0] golden_sum(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  state_t           state_r, state_s;
  logic [3:0]       drain_cnt_r;
  logic             vld_r [LATENCY];
  logic [WIDTH-1:0] pa_r  [LATENCY];
  logic [WIDTH-1:0] pb_r  [LATENCY];

  logic             start_run_s, cmp_s, mis_s, halt_s;
  logic [CNT_W-1:0] chk_s, err_s;
  logic [WIDTH-1:0] fa_s, fb_s;
  logic             busy_s, done_s, pass_s;

  // A compare is due whenever the oldest pipe stage carries a pair.
  assign start_run_s = Start && ((state_r == IDLE) || (state_r == DONE));
  assign cmp_s       = vld_r[LATENCY-1] && ((state_r == RUN) || (state_r == DRAIN));
  assign mis_s       = cmp_s &&
                       ({C16, S} != golden_sum(pa_r[LATENCY-1], pb_r[LATENCY-1]));

`ifdef CLA_CHK_HALT_EN
  assign halt_s = mis_s;
`else
  assign halt_s = 1'b0;
`endif

  // State register and drain-cycle counter.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_r     <= IDLE;
      drain_cnt_r <= 4'd0;
    end else begin
      state_r     <= state_s;
      drain_cnt_r <= (state_r == DRAIN) ? drain_cnt_r + 4'd1 : 4'd0;
    end
  end

  // Next-state logic; Start outranks Stop outside RUN because Stop is unused there.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (Start) state_s = RUN; else state_s = IDLE;
      RUN: begin
        if (halt_s)     state_s = DONE;
        else if (Stop)  state_s = DRAIN;
        else            state_s = RUN;
      end
      DRAIN: begin
        if (halt_s || (drain_cnt_r == DRAIN_LAST)) state_s = DONE;
        else                                       state_s = DRAIN;
      end
      DONE:    if (Start) state_s = RUN; else state_s = DONE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of counters and first-error capture.
  always_comb begin
    chk_s = Chk_Cnt;
    err_s = Err_Cnt;
    fa_s  = First_Err_A;
    fb_s  = First_Err_B;
    if (start_run_s) begin
      chk_s = CNT_ZERO;
      err_s = CNT_ZERO;
      fa_s  = OPD_ZERO;
      fb_s  = OPD_ZERO;
    end else begin
      if (cmp_s && (Chk_Cnt != CNT_MAX)) chk_s = Chk_Cnt + CNT_ONE;
      else                               chk_s = Chk_Cnt;
      if (mis_s && (Err_Cnt != CNT_MAX)) err_s = Err_Cnt + CNT_ONE;
      else                               err_s = Err_Cnt;
      // Only the 0 -> 1 transition of the error count captures operands.
      if (mis_s && (Err_Cnt == CNT_ZERO)) begin
        fa_s = pa_r[LATENCY-1];
        fb_s = pb_r[LATENCY-1];
      end else begin
        fa_s = First_Err_A;
        fb_s = First_Err_B;
      end
    end
  end

  // Output decode from next state, so the status outputs come straight from flops.
  always_comb begin
    busy_s = (state_s == RUN) || (state_s == DRAIN);
    done_s = (state_s == DONE);
    pass_s = done_s && (err_s == CNT_ZERO);
  end

  // Registered status and counter outputs.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Pass        <= 1'b0;
      Chk_Cnt     <= CNT_ZERO;
      Err_Cnt     <= CNT_ZERO;
      First_Err_A <= OPD_ZERO;
      First_Err_B <= OPD_ZERO;
    end else begin
      Busy        <= busy_s;
      Done        <= done_s;
      Pass        <= pass_s;
      Chk_Cnt     <= chk_s;
      Err_Cnt     <= err_s;
      First_Err_A <= fa_s;
      First_Err_B <= fb_s;
    end
  end

  // Operand delay pipe; flushed on a new run and on a halting mismatch.
  always_ff @(posedge Clk) begin
    if (!Rst || start_run_s || halt_s) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_r[i] <= 1'b0;
        pa_r[i]  <= OPD_ZERO;
        pb_r[i]  <= OPD_ZERO;
      end
    end else begin
      vld_r[0] <= In_Valid && (state_r == RUN);
      pa_r[0]  <= A;
      pb_r[0]  <= B;
      for (int i = 1; i < LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
        pa_r[i]  <= pa_r[i-1];
        pb_r[i]  <= pb_r[i-1];
      end
    end
  end

endmodule

// File: doc/cla_checker.md
# cla_checker

Self-checking result monitor for the registered 16-bit carry-lookahead adder. It sits on the adder's output side and samples each operand pair it is given, then waits the adder's pipeline latency. It compares the adder's {C16, S} against an internally computed golden sum, and reports pass/fail, a compare count, an error count, and the first failing operands. It is the consuming end of the adder's operand/result interface, so exhaustive or random sweeps can run without a simulator-side scoreboard.

## Interface
- WIDTH, 16, operand and sum width
- LATENCY, 1, cycles from operand sample edge to the edge where S/C16 hold that pair's result; legal range 1..8
- CNT_W, 32, width of the compare and error counters
- Clk  in  1  rising-edge clock
- Rst  in  1  reset, synchronous, active-low
- Start  in  1  one-cycle pulse; begins a run
- Stop  in  1  one-cycle pulse; ends a run after in-flight compares drain
- In_Valid  in  1  A/B this cycle are a pair to check
- A  in  WIDTH  operand A, same value driven to the adder
- B  in  WIDTH  operand B, same value driven to the adder
- S  in  WIDTH  adder sum output
- C16  in  1  adder carry-out
- Busy  out  1  high in RUN or DRAIN
- Done  out  1  high in DONE
- Pass  out  1  valid in DONE; 1 when Err_Cnt == 0
- Chk_Cnt  out  CNT_W  compares performed, saturating
- Err_Cnt  out  CNT_W  mismatches, saturating
- First_Err_A  out  WIDTH  A of the first mismatch
- First_Err_B  out  WIDTH  B of the first mismatch

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE to RUN on Start. DONE to RUN on Start. Entering RUN clears the counters, First_Err_A/B, and the delay pipe.
- RUN to DRAIN on Stop. Stop together with Start in IDLE or DONE: Start wins, and Stop is ignored.
- DRAIN lasts exactly LATENCY cycles, then goes to DONE. In_Valid is ignored in DRAIN.
- DONE holds until the next Start. Stop, In_Valid and Start all have no effect in IDLE, except Start as above.
- Delay pipe: LATENCY stages of {valid, A, B}. Stage 0 loads {In_Valid & RUN, A, B} every edge.
- Golden value is the (WIDTH+1)-bit zero-extended A+B. Compare when the last stage is valid: mismatch if {C16,S} != golden.
- Each compare increments Chk_Cnt. Each mismatch increments Err_Cnt. Both counters saturate at all-ones and never wrap.
- First_Err_A/B latch only on the mismatch that moves Err_Cnt from 0 to 1.
- Pass = Done & (Err_Cnt == 0). Pass is 0 outside DONE.

## Timing
- Reset values (Rst low at an edge): state IDLE, Busy 0, Done 0, Pass 0, Chk_Cnt 0, Err_Cnt 0, First_Err_A/B 0, pipe valid bits 0.
- Reset asserted mid-RUN or mid-DRAIN: the next edge returns to IDLE and discards in-flight pairs. No partial counts survive.
- A pair sampled at edge n with In_Valid=1 is compared against S/C16 sampled at edge n+LATENCY. The counter update is visible after that edge.
- Start sampled at edge n: Busy=1 after edge n. The first pair that can be checked is sampled at edge n+1.
- Stop sampled at edge n: In_Valid at edge n is still accepted. DRAIN covers edges n+1..n+LATENCY, and Done=1 after edge n+LATENCY.
- Back-to-back In_Valid on every cycle is supported at full throughput; there is no backpressure.

## Configuration
- CLA_CHK_HALT_EN defined:
  - The first mismatch moves the FSM straight from RUN or DRAIN to DONE at the edge where it is detected.
  - Remaining in-flight pairs are discarded, and Err_Cnt stops at 1.
- CLA_CHK_HALT_EN undefined: the run continues through all mismatches, as described above.

## Test plan
- Reset then idle: Rst low 2 cycles then high, no Start -> all outputs 0, state IDLE.
- Correct adder, LATENCY=1: Start, then pairs (0xFFFF,0x0001), (0x1234,0x4321), (0,0), then Stop, with the adder giving {1,0x0000}, {0,0x5555}, {0,0x0000} -> Done after 1 drain cycle, Chk_Cnt=3, Err_Cnt=0, Pass=1.
- Fault injection: force S bit 3 high for the pair (0x0000,0x0000) -> Err_Cnt=1, First_Err_A=0, First_Err_B=0, Pass=0. A second fault on (0x0001,0x0001) -> Err_Cnt=2, First_Err unchanged.
- Stop with pairs in flight, LATENCY=3: In_Valid every cycle for 5 pairs, Stop together with the 5th -> Chk_Cnt=5, with Done exactly 3 cycles after Stop.
- Reset mid-RUN after 2 of 4 pairs -> IDLE, counters 0. A fresh Start and 1 pair -> Chk_Cnt=1.
- With CLA_CHK_HALT_EN: fault on the 2nd of 4 pairs -> Done at that compare edge, Chk_Cnt=2, Err_Cnt=1. Without the macro, the same stimulus gives Chk_Cnt=4.
